// File: rtl/zoom_line_buffer_pkg.sv
// Shared types for the zoom line buffer: expansion modes, FSM states, default pixel type.
package zoom_pkg;

  typedef enum logic [1:0] {
    NONE       = 2'b00,
    COPY       = 2'b01,
    LINEAR     = 2'b10,
    LINEAR_ALT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    EXPAND,
    DONE
  } state_e;

  localparam int DEF_CH_W = 4;
  localparam int DEF_NCH  = 3;

  typedef logic [DEF_CH_W*DEF_NCH-1:0] pixel_t;

  localparam pixel_t FILL_COLOR_DEF = 12'h444;

endpackage

// File: rtl/zoom_line_buffer_lerp.sv
// Per-channel linear blend between neighbouring source pixels, floor-truncated.
module pixel_lerp #(
  parameter int CH_W       = 4,
  parameter int NCH        = 3,
  parameter int SCALE_LOG2 = 2
) (
  input  logic [NCH*CH_W-1:0]   a,
  input  logic [NCH*CH_W-1:0]   b,
  input  logic [SCALE_LOG2-1:0] j,
  output logic [NCH*CH_W-1:0]   y
);

  localparam int IW = CH_W + SCALE_LOG2 + 1;
  localparam logic [SCALE_LOG2:0] S = (SCALE_LOG2+1)'(1) << SCALE_LOG2;

  logic [SCALE_LOG2:0] wb;
  logic [SCALE_LOG2:0] wa;
  logic [IW-1:0]       acc;

  always_comb begin
    wb  = {1'b0, j};
    wa  = S - wb;
    y   = '0;
    acc = '0;
    for (int c = 0; c < NCH; c++) begin
      acc = IW'(a[c*CH_W +: CH_W]) * IW'(wa) + IW'(b[c*CH_W +: CH_W]) * IW'(wb);
      y[c*CH_W +: CH_W] = CH_W'(acc >> SCALE_LOG2);
    end
  end

endmodule

// File: rtl/zoom_line_buffer.sv
// Fetches one source row segment, expands it horizontally by 2^SCALE_LOG2 and
// serves it to the display from a ping-pong line buffer.
//   state  | meaning
//   IDLE   | waiting for line_req
//   FETCH  | issuing SRC_W frame buffer reads
//   DRAIN  | capturing the last read sample
//   EXPAND | writing OUT_W pixels into the write bank
//   DONE   | line_done pulse, banks swap
module zoom_line_buffer
  import zoom_pkg::*;
#(
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int FB_AW      = 17,
  parameter int CH_W       = 4,
  parameter int NCH        = 3,
  parameter int SRC_W      = 80,
  parameter int SCALE_LOG2 = 2,
  parameter logic [NCH*CH_W-1:0] FILL_COLOR = FILL_COLOR_DEF,
  localparam int PIX_W = NCH*CH_W,
  localparam int OUT_W = SRC_W << SCALE_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [9:0]       x_offset,
  input  logic [9:0]       y_offset,
  input  logic             line_req,
  input  logic [9:0]       src_row,
  output logic             busy,
  output logic             line_done,
  output logic             fb_re,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [PIX_W-1:0] fb_data,
  input  logic             rd_en,
  input  logic [9:0]       rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  localparam int SW  = $clog2(SRC_W);
  localparam int OWB = $clog2(OUT_W);
  localparam int RW  = $clog2(2*OUT_W);
  localparam logic [9:0] OUT_W_A = 10'(OUT_W);

  state_e           state;
  mode_e            mode_q;
  logic [9:0]       xo_q, yo_q, row_q;
  logic [SW-1:0]    k;
  logic [OWB-1:0]   i;
  logic             rbank;

  logic [PIX_W-1:0] src [SRC_W];
  logic [PIX_W-1:0] ram [2*OUT_W];

  logic [SW-1:0]         m, m_nxt;
  logic [SCALE_LOG2-1:0] j;
  logic [PIX_W-1:0]      pa, pb, lerp_pix, wr_pix;
  logic [RW-1:0]         wr_idx, rd_idx;

  // Clamped frame buffer address; out-of-frame requests replicate the edge pixel.
  function automatic logic [FB_AW-1:0] addr_of(input logic [9:0] xo, input logic [9:0] yo,
                                               input logic [9:0] row, input logic [SW-1:0] kk);
    logic [19:0] yc, xc, a;
    yc = 20'(row) + 20'(yo);
    if (yc > 20'(FB_H-1)) yc = 20'(FB_H-1);
    xc = 20'(xo) + 20'(kk);
    if (xc > 20'(FB_W-1)) xc = 20'(FB_W-1);
    a = yc * 20'(FB_W) + xc;
    return FB_AW'(a);
  endfunction

  assign m     = i[OWB-1:SCALE_LOG2];
  assign j     = i[SCALE_LOG2-1:0];
  assign m_nxt = (m == SW'(SRC_W-1)) ? m : m + SW'(1);
  assign pa    = src[m];
  assign pb    = src[m_nxt];

  pixel_lerp #(.CH_W(CH_W), .NCH(NCH), .SCALE_LOG2(SCALE_LOG2)) u_lerp (
    .a (pa),
    .b (pb),
    .j (j),
    .y (lerp_pix)
  );

  always_comb begin
    wr_pix = lerp_pix;
    case (mode_q)
      NONE:    wr_pix = (j == '0) ? pa : FILL_COLOR;
      COPY:    wr_pix = pa;
      default: wr_pix = lerp_pix;
    endcase
  end

  // Write bank is always the complement of the read bank.
  assign wr_idx = rbank ? RW'(i) : RW'(OUT_W) + RW'(i);
  assign rd_idx = rbank ? RW'(OUT_W) + RW'(rd_addr) : RW'(rd_addr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      line_done <= 1'b0;
      fb_re     <= 1'b0;
      fb_addr   <= '0;
      rbank     <= 1'b0;
      mode_q    <= NONE;
      xo_q      <= '0;
      yo_q      <= '0;
      row_q     <= '0;
      k         <= '0;
      i         <= '0;
    end else begin
      line_done <= 1'b0;
      case (state)
        IDLE: begin
          if (line_req) begin
            mode_q  <= mode_e'(mode);
            xo_q    <= x_offset;
            yo_q    <= y_offset;
            row_q   <= src_row;
            k       <= '0;
            busy    <= 1'b1;
            fb_re   <= 1'b1;
            fb_addr <= addr_of(x_offset, y_offset, src_row, '0);
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (k == SW'(SRC_W-1)) begin
            fb_re <= 1'b0;
            state <= DRAIN;
          end else begin
            k       <= k + SW'(1);
            fb_addr <= addr_of(xo_q, yo_q, row_q, k + SW'(1));
          end
        end
        DRAIN: begin
          i     <= '0;
          state <= EXPAND;
        end
        EXPAND: begin
          if (i == OWB'(OUT_W-1)) begin
            busy      <= 1'b0;
            line_done <= 1'b1;
            state     <= DONE;
          end else begin
            i <= i + OWB'(1);
          end
        end
        DONE: begin
          rbank <= ~rbank;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data for request k arrives while request k+1 is on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == FETCH && k != '0) src[k - SW'(1)] <= fb_data;
      if (state == DRAIN) src[SW'(SRC_W-1)] <= fb_data;
      if (state == EXPAND) ram[wr_idx] <= wr_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (rd_addr < OUT_W_A) ? ram[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_zoom_line_buffer.sv
// Self-checking bench for zoom_line_buffer against a behavioural line model.
module tb_zoom_line_buffer;

  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int SRC_W = 80;
  localparam int S     = 4;
  localparam int OUT_W = SRC_W * S;
  localparam int MEMSZ = 131072;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode;
  logic [9:0]  x_offset, y_offset, src_row, rd_addr;
  logic        line_req, rd_en;
  logic        busy, line_done, fb_re;
  logic [16:0] fb_addr;
  logic [11:0] fb_data, rd_data;

  zoom_line_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .x_offset  (x_offset),
    .y_offset  (y_offset),
    .line_req  (line_req),
    .src_row   (src_row),
    .busy      (busy),
    .line_done (line_done),
    .fb_re     (fb_re),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  logic [11:0] fbmem [MEMSZ];
  always @(posedge clk) if (fb_re) fb_data <= fbmem[fb_addr];

  int tests = 0;
  int fails = 0;

  logic [11:0] exp_line [OUT_W];
  logic [11:0] got_line [OUT_W];

  int b_lat, b_reads, b_addr_err, b_last_addr, b_timeout, b_done_cnt, b_busy_err;

  function automatic int model_addr(input int x, input int y, input int row, input int k);
    int yc, xc;
    yc = row + y;
    if (yc > FB_H-1) yc = FB_H-1;
    xc = x + k;
    if (xc > FB_W-1) xc = FB_W-1;
    return (yc*FB_W + xc) % MEMSZ;
  endfunction

  task automatic model_line(input int md, input int x, input int y, input int row);
    logic [11:0] sp [SRC_W];
    logic [11:0] a, b, e;
    int m, j, ca, cb, v;
    for (int k = 0; k < SRC_W; k++) sp[k] = fbmem[model_addr(x, y, row, k)];
    for (int p = 0; p < OUT_W; p++) begin
      m = p / S;
      j = p % S;
      a = sp[m];
      b = sp[(m+1 < SRC_W) ? m+1 : SRC_W-1];
      if (j == 0)       e = a;
      else if (md == 0) e = 12'h444;
      else if (md == 1) e = a;
      else begin
        e = '0;
        for (int c = 0; c < 3; c++) begin
          ca = int'(a[4*c +: 4]);
          cb = int'(b[4*c +: 4]);
          v  = (ca*(S-j) + cb*j) / S;
          e[4*c +: 4] = 4'(v);
        end
      end
      exp_line[p] = e;
    end
  endtask

  // Issues one request and records what the DUT did until line_done.
  task automatic build(input int md, input int x, input int y, input int row, input bit extra);
    @(negedge clk);
    mode = 2'(md); x_offset = 10'(x); y_offset = 10'(y); src_row = 10'(row);
    line_req = 1'b1;
    b_lat = 0; b_reads = 0; b_addr_err = 0; b_last_addr = -1;
    b_timeout = 1; b_done_cnt = 0; b_busy_err = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      line_req = 1'b0;
      b_lat++;
      if (extra && (t == 50 || t == 200)) line_req = 1'b1;
      if (fb_re) begin
        if (fb_addr !== 17'(model_addr(x, y, row, b_reads))) b_addr_err++;
        b_last_addr = int'(fb_addr);
        b_reads++;
      end
      if (!line_done && busy !== 1'b1) b_busy_err++;
      if (line_done && busy !== 1'b0) b_busy_err++;
      if (line_done) begin
        b_done_cnt++;
        b_timeout = 0;
        if (extra) line_req = 1'b1;
        break;
      end
    end
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic read_line();
    for (int p = 0; p <= OUT_W; p++) begin
      @(negedge clk);
      if (p > 0) got_line[p-1] = rd_data;
      rd_en = 1'b1;
      if (p < OUT_W) rd_addr = 10'(p);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (line_done !== 1'b0)  begin fails++; $display("FAIL reset_done got %b exp 0", line_done); end
    tests++; if (fb_re !== 1'b0)      begin fails++; $display("FAIL reset_fb_re got %b exp 0", fb_re); end
    tests++; if (fb_addr !== 17'h0)   begin fails++; $display("FAIL reset_fb_addr got %h exp 0", fb_addr); end
    tests++; if (rd_data !== 12'h000) begin fails++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_copy();
    for (int k = 0; k < SRC_W; k++) fbmem[5*FB_W + k] = {4'h0, 4'(k), 4'h0};
    build(1, 0, 0, 5, 1'b0);
    tests++; if (b_timeout != 0)   begin fails++; $display("FAIL copy_timeout no line_done"); end
    tests++; if (b_lat != 402)     begin fails++; $display("FAIL copy_latency got %0d exp 402", b_lat); end
    tests++; if (b_reads != SRC_W) begin fails++; $display("FAIL copy_reads got %0d exp %0d", b_reads, SRC_W); end
    tests++; if (b_addr_err != 0)  begin fails++; $display("FAIL copy_addr bad addresses %0d exp 0", b_addr_err); end
    tests++; if (b_busy_err != 0)  begin fails++; $display("FAIL copy_busy bad cycles %0d exp 0", b_busy_err); end
    read_line();
    for (int p = 8; p < 12; p++) begin
      tests++;
      if (got_line[p] !== 12'h020) begin fails++; $display("FAIL copy_px[%0d] got %h exp 020", p, got_line[p]); end
    end
    model_line(1, 0, 0, 5);
    for (int p = 0; p < OUT_W; p++) begin
      tests++;
      if (got_line[p] !== exp_line[p]) begin fails++; $display("FAIL copy_line[%0d] got %h exp %h", p, got_line[p], exp_line[p]); end
    end
  endtask

  task automatic test_linear();
    logic [11:0] ramp [5];
    ramp[0] = 12'h000; ramp[1] = 12'h333; ramp[2] = 12'h777; ramp[3] = 12'hBBB; ramp[4] = 12'hFFF;
    fbmem[10*FB_W + 20]      = 12'h000;
    fbmem[10*FB_W + 21]      = 12'hFFF;
    fbmem[10*FB_W + 20 + 79] = 12'hABC;
    build(2, 20, 3, 7, 1'b0);
    tests++; if (b_timeout != 0)  begin fails++; $display("FAIL lin_timeout no line_done"); end
    tests++; if (b_addr_err != 0) begin fails++; $display("FAIL lin_addr bad addresses %0d exp 0", b_addr_err); end
    read_line();
    for (int p = 0; p < 5; p++) begin
      tests++;
      if (got_line[p] !== ramp[p]) begin fails++; $display("FAIL lin_ramp[%0d] got %h exp %h", p, got_line[p], ramp[p]); end
    end
    for (int p = 316; p < 320; p++) begin
      tests++;
      if (got_line[p] !== 12'hABC) begin fails++; $display("FAIL lin_tail[%0d] got %h exp ABC", p, got_line[p]); end
    end
    model_line(2, 20, 3, 7);
    for (int p = 0; p < OUT_W; p++) begin
      tests++;
      if (got_line[p] !== exp_line[p]) begin fails++; $display("FAIL lin_line[%0d] got %h exp %h", p, got_line[p], exp_line[p]); end
    end
    build(3, 40, 60, 100, 1'b0);
    tests++; if (b_timeout != 0) begin fails++; $display("FAIL lin3_timeout no line_done"); end
    read_line();
    model_line(3, 40, 60, 100);
    for (int p = 0; p < OUT_W; p++) begin
      tests++;
      if (got_line[p] !== exp_line[p]) begin fails++; $display("FAIL lin3_line[%0d] got %h exp %h", p, got_line[p], exp_line[p]); end
    end
  endtask

  task automatic test_none();
    build(0, 50, 0, 12, 1'b0);
    tests++; if (b_timeout != 0) begin fails++; $display("FAIL none_timeout no line_done"); end
    read_line();
    for (int p = 1; p < 4; p++) begin
      tests++;
      if (got_line[p] !== 12'h444) begin fails++; $display("FAIL none_fill[%0d] got %h exp 444", p, got_line[p]); end
    end
    tests++;
    if (got_line[4] !== fbmem[12*FB_W + 51]) begin fails++; $display("FAIL none_px4 got %h exp %h", got_line[4], fbmem[12*FB_W + 51]); end
    model_line(0, 50, 0, 12);
    for (int p = 0; p < OUT_W; p++) begin
      tests++;
      if (got_line[p] !== exp_line[p]) begin fails++; $display("FAIL none_line[%0d] got %h exp %h", p, got_line[p], exp_line[p]); end
    end
  endtask

  task automatic test_clamp();
    build(1, 300, 235, 10, 1'b0);
    tests++; if (b_timeout != 0)     begin fails++; $display("FAIL clamp_timeout no line_done"); end
    tests++; if (b_addr_err != 0)    begin fails++; $display("FAIL clamp_addr bad addresses %0d exp 0", b_addr_err); end
    tests++; if (b_last_addr != 76799) begin fails++; $display("FAIL clamp_last_addr got %0d exp 76799", b_last_addr); end
    read_line();
    model_line(1, 300, 235, 10);
    for (int p = 0; p < OUT_W; p++) begin
      tests++;
      if (got_line[p] !== exp_line[p]) begin fails++; $display("FAIL clamp_line[%0d] got %h exp %h", p, got_line[p], exp_line[p]); end
    end
  endtask

  task automatic test_random();
    int md, x, y, row;
    for (int n = 0; n < 4; n++) begin
      md  = int'($urandom_range(0, 3));
      x   = int'($urandom_range(0, 330));
      y   = int'($urandom_range(0, 250));
      row = int'($urandom_range(0, 20));
      build(md, x, y, row, 1'b0);
      tests++; if (b_timeout != 0)  begin fails++; $display("FAIL rand_timeout iter %0d", n); end
      tests++; if (b_addr_err != 0) begin fails++; $display("FAIL rand_addr iter %0d bad %0d exp 0", n, b_addr_err); end
      read_line();
      model_line(md, x, y, row);
      for (int p = 0; p < OUT_W; p++) begin
        tests++;
        if (got_line[p] !== exp_line[p]) begin fails++; $display("FAIL rand_line[%0d] mode %0d got %h exp %h", p, md, got_line[p], exp_line[p]); end
      end
    end
  endtask

  task automatic test_ping_pong();
    logic [11:0] l1_0, l2_0;
    int bad, seen;
    fbmem[31*FB_W] = ~fbmem[30*FB_W];
    build(1, 0, 0, 30, 1'b0);
    model_line(1, 0, 0, 30);
    l1_0 = exp_line[0];
    model_line(1, 0, 0, 31);
    l2_0 = exp_line[0];
    @(negedge clk);
    mode = 2'd1; x_offset = '0; y_offset = '0; src_row = 10'd31;
    line_req = 1'b1; rd_en = 1'b1; rd_addr = '0;
    bad = 0; seen = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      line_req = 1'b0;
      if (rd_data !== l1_0) bad++;
      if (line_done) begin seen = 1; break; end
    end
    tests++; if (seen != 1) begin fails++; $display("FAIL pp_timeout no line_done"); end
    tests++; if (bad != 0)  begin fails++; $display("FAIL pp_hold reads changed %0d times exp 0", bad); end
    @(negedge clk);
    tests++; if (rd_data !== l1_0) begin fails++; $display("FAIL pp_swap_read got %h exp %h", rd_data, l1_0); end
    @(negedge clk);
    tests++; if (rd_data !== l2_0) begin fails++; $display("FAIL pp_new_read got %h exp %h", rd_data, l2_0); end
    rd_en = 1'b0;
    rd_addr = 10'd5;
    @(negedge clk);
    tests++; if (rd_data !== l2_0) begin fails++; $display("FAIL rd_hold got %h exp %h", rd_data, l2_0); end
    rd_en = 1'b1; rd_addr = 10'd320;
    @(negedge clk);
    tests++; if (rd_data !== 12'h000) begin fails++; $display("FAIL rd_oob320 got %h exp 000", rd_data); end
    rd_addr = 10'd1;
    @(negedge clk);
    rd_addr = 10'd1023;
    @(negedge clk);
    tests++; if (rd_data !== 12'h000) begin fails++; $display("FAIL rd_oob1023 got %h exp 000", rd_data); end
    rd_en = 1'b0;
    read_line();
    model_line(1, 0, 0, 31);
    for (int p = 0; p < OUT_W; p++) begin
      tests++;
      if (got_line[p] !== exp_line[p]) begin fails++; $display("FAIL pp_line[%0d] got %h exp %h", p, got_line[p], exp_line[p]); end
    end
  endtask

  task automatic test_busy_ignore();
    int bad;
    build(2, 7, 9, 33, 1'b1);
    tests++; if (b_timeout != 0)  begin fails++; $display("FAIL ign_timeout no line_done"); end
    tests++; if (b_done_cnt != 1) begin fails++; $display("FAIL ign_done_cnt got %0d exp 1", b_done_cnt); end
    tests++; if (b_lat != 402)    begin fails++; $display("FAIL ign_latency got %0d exp 402", b_lat); end
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (busy !== 1'b0 || line_done !== 1'b0 || fb_re !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL ign_requeue active cycles %0d exp 0", bad); end
    read_line();
    model_line(2, 7, 9, 33);
    for (int p = 0; p < OUT_W; p++) begin
      tests++;
      if (got_line[p] !== exp_line[p]) begin fails++; $display("FAIL ign_line[%0d] got %h exp %h", p, got_line[p], exp_line[p]); end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    mode = 2'd1; x_offset = 10'd3; y_offset = 10'd4; src_row = 10'd40; line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    repeat (10) @(negedge clk);
    tests++; if (fb_re !== 1'b1) begin fails++; $display("FAIL mid_fetch_active fb_re got %b exp 1", fb_re); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    tests++; if (fb_re !== 1'b0)     begin fails++; $display("FAIL mid_rst_fb_re got %b exp 0", fb_re); end
    tests++; if (line_done !== 1'b0) begin fails++; $display("FAIL mid_rst_done got %b exp 0", line_done); end
    reset = 1'b1;
    bad = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (busy !== 1'b0 || line_done !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL mid_no_resume active cycles %0d exp 0", bad); end
    build(1, 10, 10, 40, 1'b0);
    tests++; if (b_timeout != 0) begin fails++; $display("FAIL mid_fresh_timeout no line_done"); end
    tests++; if (b_lat != 402)   begin fails++; $display("FAIL mid_fresh_latency got %0d exp 402", b_lat); end
    read_line();
    model_line(1, 10, 10, 40);
    for (int p = 0; p < OUT_W; p++) begin
      tests++;
      if (got_line[p] !== exp_line[p]) begin fails++; $display("FAIL mid_line[%0d] got %h exp %h", p, got_line[p], exp_line[p]); end
    end
  endtask

  initial begin
    mode = '0; x_offset = '0; y_offset = '0; src_row = '0;
    line_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
    for (int a = 0; a < MEMSZ; a++) fbmem[a] = 12'($urandom);
    test_reset();
    test_copy();
    test_linear();
    test_none();
    test_clamp();
    test_random();
    test_ping_pong();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zoom_line_buffer.md
Name: zoom_line_buffer

Overview:
- Parametrised successor to the region line buffers. On request, fetches one source row segment of SRC_W pixels from the frame buffer at a latched (x_offset, y_offset) region origin.
- Expands the segment by 2^SCALE_LOG2 into an output line using none/copy/linear mode.
- Output line is held in a ping-pong buffer, so the display side reads line N while line N+1 is built.
- Sits between the frame buffer read port and the VGA pixel mux.

Parameters:
- FB_W, 320, frame buffer width in pixels.
- FB_H, 240, frame buffer height in pixels.
- FB_AW, 17, frame buffer address width.
- CH_W, 4, bits per colour channel.
- NCH, 3, channel count; pixel width PIX_W = NCH*CH_W.
- SRC_W, 80, source pixels fetched per line.
- SCALE_LOG2, 2, horizontal zoom factor S = 2^SCALE_LOG2.
- FILL_COLOR, 12'h444, value for non-sample positions in mode NONE.
- Derived, not overridable: OUT_W = SRC_W << SCALE_LOG2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- mode  in  2  00 NONE, 01 COPY, 10 LINEAR, 11 treated as LINEAR
- x_offset  in  10  region origin x
- y_offset  in  10  region origin y
- line_req  in  1  single-cycle pulse: build a line
- src_row  in  10  region-relative source row for this request
- busy  out  1  high from the cycle after an accepted request until done
- line_done  out  1  one-cycle pulse when the line is complete; banks swap in the same cycle
- fb_re  out  1  frame buffer read enable
- fb_addr  out  FB_AW  frame buffer read address
- fb_data  in  PIX_W  frame buffer data, valid 1 cycle after fb_re
- rd_en  in  1  display read enable
- rd_addr  in  10  output pixel index, 0..OUT_W-1
- rd_data  out  PIX_W  registered output pixel, 1-cycle latency

Behaviour:
- Reset (reset==0 at clk edge):
  - State IDLE; busy=0, line_done=0, fb_re=0, fb_addr=0, rd_data=0.
  - Write bank = 1, read bank = 0. Buffer contents are not cleared.
  - A reset mid-operation abandons the line; no line_done is issued.
- FSM states: IDLE, FETCH, DRAIN, EXPAND, DONE.
- IDLE:
  - line_req=1 latches mode, x_offset, y_offset, src_row and goes to FETCH.
  - line_req in any other state is ignored; no queueing.
- FETCH (SRC_W cycles, k = 0..SRC_W-1):
  - fb_re=1, fb_addr = yc*FB_W + xc, where yc = min(src_row+y_offset, FB_H-1) and xc = min(x_offset+k, FB_W-1).
  - Arithmetic is done at 20 bits, then truncated to FB_AW.
  - fb_data arriving at cycle k+1 is stored in the internal source array src[k].
- DRAIN (1 cycle): fb_re=0; captures the final sample src[SRC_W-1].
- EXPAND (OUT_W cycles, i = 0..OUT_W-1): one write per cycle into the write bank, with m = i>>SCALE_LOG2 and j = i & (S-1).
  - j==0: out[i] = src[m] in every mode.
  - NONE: out[i] = FILL_COLOR.
  - COPY: out[i] = src[m].
  - LINEAR, per channel: out = (a*(S-j) + b*j) >> SCALE_LOG2, with a = src[m] and b = src[min(m+1, SRC_W-1)].
    - Intermediate width is CH_W+SCALE_LOG2+1; floor truncation; no rounding.
    - The last source pixel therefore replicates to the line end.
- DONE (1 cycle):
  - line_done=1, busy=0 in this cycle.
  - Write and read banks swap, then return to IDLE.
  - A line_req in this cycle is ignored.
- Latency: line_req to line_done = SRC_W + OUT_W + 2 cycles (402 with defaults).
- Read side:
  - rd_en=1 gives rd_data = readbank[rd_addr] next cycle; rd_en=0 holds rd_data.
  - rd_addr >= OUT_W returns 0.
  - A read in the swap cycle uses the pre-swap bank.
  - Reads never observe the bank being written.

Decomposition:
- Package zoom_pkg holds:
  - mode_e enum (NONE, COPY, LINEAR, LINEAR_ALT).
  - state_e enum.
  - Default FILL_COLOR constant.
  - pixel_t typedef, parameterised by channel width via a localparam in the module.
- Sub-module pixel_lerp: combinational, parameters CH_W, NCH, SCALE_LOG2; inputs a, b, j; output the interpolated pixel.
- The ping-pong RAM stays inline as a 2*OUT_W array.

Test Plan:
- COPY, src pixel k = 12'h0k0 pattern at row 5, offsets (0,0) → after line_done, rd_addr 8..11 return 12'h020; latency measures exactly 402 cycles.
- LINEAR, src[0]=12'h000, src[1]=12'hFFF → out[0..4] = 000, 333, 777, BBB, FFF; src[79]=12'hABC → out[316..319] all 12'hABC.
- NONE → out[0]=src[0], out[1..3]=12'h444, out[4]=src[1].
- Clamp: x_offset=300, y_offset=235, src_row=10 → fb_addr uses row 239; samples k≥20 read address 239*320+319.
- Ping-pong: during a second build, repeated reads of rd_addr 0 stay equal to line 1 data until the line_done cycle; the next read returns line 2 data.
- line_req while busy is ignored (single line_done); reset asserted mid-FETCH → busy=0 and fb_re=0 next cycle, no line_done, and a fresh request completes correctly.
